// File: rtl/cla5_pkg.sv
// cla5_pkg: shared constants and helpers for the shared 5-bit CLA scheduler.
package cla5_pkg;
   localparam int CLA_W     = 5;
   localparam int MAX_REQ   = 8;
   localparam int MAX_ID_W  = 3;

   // Tag carried alongside the adder pipeline is {valid, id}, packed MSB-first.
   function automatic int tag_width(input int id_w);
      return 1 + id_w;
   endfunction

   // Round-robin search from ptr, wrapping mod n; returns {found, id}.
   function automatic logic [MAX_ID_W:0] rr_pick(input logic [MAX_REQ-1:0] valid,
                                                 input logic [MAX_ID_W-1:0] ptr,
                                                 input int n);
      logic [MAX_ID_W:0] r;
      int idx;
      r = '0;
      for (int i = n - 1; i >= 0; i--) begin
         idx = (int'(ptr) + i) % n;
         if (valid[idx]) r = {1'b1, MAX_ID_W'(idx)};
      end
      return r;
   endfunction
endpackage

// File: rtl/cla5_rr_scheduler_if.sv
// cla5_rr_scheduler_if: requester, adder and response signals of the scheduler.
interface cla5_rr_scheduler_if #(
   parameter int NUM_REQ   = 4,
   parameter int ADDER_LAT = 2,
   parameter int CNT_W     = 16
);
   import cla5_pkg::*;
   localparam int ID_W = $clog2(NUM_REQ);
   localparam int IF_W = $clog2(ADDER_LAT + 1);
   logic [NUM_REQ-1:0]       req_valid;
   logic [CLA_W*NUM_REQ-1:0] req_a;
   logic [CLA_W*NUM_REQ-1:0] req_b;
   logic [NUM_REQ-1:0]       req_cin;
   logic [NUM_REQ-1:0]       req_ready;
   logic                     hold;
   logic [CLA_W-1:0]         add_a;
   logic [CLA_W-1:0]         add_b;
   logic                     add_cin;
   logic [CLA_W-1:0]         add_sum;
   logic                     add_cout;
   logic                     rsp_valid;
   logic [ID_W-1:0]          rsp_id;
   logic [CLA_W-1:0]         rsp_sum;
   logic                     rsp_cout;
   logic [IF_W-1:0]          inflight;
   logic [CNT_W-1:0]         op_count;

   modport slave (
      input  req_valid, req_a, req_b, req_cin, hold, add_sum, add_cout,
      output req_ready, add_a, add_b, add_cin, rsp_valid, rsp_id, rsp_sum, rsp_cout,
             inflight, op_count
   );

   modport master (
      output req_valid, req_a, req_b, req_cin, hold, add_sum, add_cout,
      input  req_ready, add_a, add_b, add_cin, rsp_valid, rsp_id, rsp_sum, rsp_cout,
             inflight, op_count
   );
endinterface

// File: rtl/cla5_tag_pipe.sv
// cla5_tag_pipe: {valid,id} shift register that tracks ops through the adder.
module cla5_tag_pipe #(
   parameter int W     = 3,
   parameter int DEPTH = 2
) (
   input  logic         clk_i,
   input  logic         reset_i,
   input  logic [W-1:0] tag_i,
   output logic [W-1:0] tag_o
);
   logic [W-1:0] pipe_q [DEPTH];

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         for (int i = 0; i < DEPTH; i++) pipe_q[i] <= '0;
      end else begin
         pipe_q[0] <= tag_i;
         for (int i = 1; i < DEPTH; i++) pipe_q[i] <= pipe_q[i-1];
      end
   end

   assign tag_o = pipe_q[DEPTH-1];
endmodule

// File: rtl/cla5_rr_scheduler.sv
// cla5_rr_scheduler: round-robin sharing of one pipelined 5-bit CLA adder,
// returning each result tagged with the requester ID that issued it.
module cla5_rr_scheduler
   import cla5_pkg::*;
#(
   parameter int NUM_REQ   = 4,
   parameter int ADDER_LAT = 2,
   parameter int ID_W      = $clog2(NUM_REQ),
   parameter int CNT_W     = 16
) (
   input logic                clk_i,
   input logic                reset_i,
   cla5_rr_scheduler_if.slave bus
);
   localparam int IF_W  = $clog2(ADDER_LAT + 1);
   localparam int TAG_W = tag_width(ID_W);

   logic [MAX_ID_W:0] pick;
   logic              grant;
   logic [ID_W-1:0]   win;
   logic [ID_W-1:0]   ptr_q, ptr_d;
   logic [IF_W-1:0]   inflight_q, inflight_d;
   logic [CNT_W-1:0]  op_count_q, op_count_d;
   logic [TAG_W-1:0]  tag_in, tag_out;

   always_comb begin
      pick          = rr_pick(MAX_REQ'(bus.req_valid), MAX_ID_W'(ptr_q), NUM_REQ);
      grant         = pick[MAX_ID_W] & ~bus.hold & ~reset_i;
      win           = ID_W'(pick[MAX_ID_W-1:0]);
      bus.req_ready = grant ? NUM_REQ'(1) << win : '0;
      bus.add_a     = grant ? bus.req_a[win*CLA_W +: CLA_W] : '0;
      bus.add_b     = grant ? bus.req_b[win*CLA_W +: CLA_W] : '0;
      bus.add_cin   = grant & bus.req_cin[win];
      // Pointer only advances on a grant, so requesters waiting through hold keep priority.
      ptr_d         = !grant ? ptr_q : (32'(win) == NUM_REQ - 1) ? '0 : win + 1'b1;
      tag_in        = {grant, win};
      inflight_d    = inflight_q + IF_W'(grant) - IF_W'(tag_out[TAG_W-1]);
      op_count_d    = op_count_q + CNT_W'(grant);
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         ptr_q      <= '0;
         inflight_q <= '0;
         op_count_q <= '0;
      end else begin
         ptr_q      <= ptr_d;
         inflight_q <= inflight_d;
         op_count_q <= op_count_d;
      end
   end

   cla5_tag_pipe #(.W(TAG_W), .DEPTH(ADDER_LAT)) u_tag_pipe (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .tag_i   (tag_in),
      .tag_o   (tag_out)
   );

   assign bus.rsp_valid = tag_out[TAG_W-1];
   assign bus.rsp_id    = tag_out[ID_W-1:0];
   assign bus.rsp_sum   = bus.add_sum;
   assign bus.rsp_cout  = bus.add_cout;
   assign bus.inflight  = inflight_q;
   assign bus.op_count  = op_count_q;
endmodule
